// File: rtl/bg_pkg.sv
// Shared types and constants for the scrolling background layer:
// scroll-mode encoding and the 16-entry 4:4:4 background palette.
package bg_pkg;

    typedef enum logic [1:0] {
        BG_STATIC = 2'b00,
        BG_AUTO_X = 2'b01,
        BG_AUTO_Y = 2'b10,
        BG_MANUAL = 2'b11
    } bg_scroll_mode_e;

    localparam int BG_PAL_ENTRIES = 16;

    // Entry 0 occupies the least significant 12 bits.
    localparam logic [BG_PAL_ENTRIES*12-1:0] BG_PALETTE = {
        12'h133, 12'h444, 12'h323, 12'h233,
        12'h133, 12'h144, 12'h233, 12'h333,
        12'h113, 12'h233, 12'h233, 12'h223,
        12'hccc, 12'h233, 12'h233, 12'h222
    };

    function automatic logic [11:0] bg_palette_lookup(input logic [3:0] idx);
        return BG_PALETTE[idx*12 +: 12];
    endfunction

endpackage

// File: rtl/layer_background_scroll_if.sv
// Read port between the background layer and its external palette-index memory.
interface layer_background_scroll_if #(
    parameter int ADDR_W   = 17,
    parameter int PAL_BITS = 4
);
    logic [ADDR_W-1:0]   mem_addr;
    logic [PAL_BITS-1:0] mem_data;

    modport master (output mem_addr, input mem_data);
    modport slave  (input mem_addr, output mem_data);
endinterface

// File: rtl/bg_scroll_offset.sv
// Frame-tick detector plus the X/Y scroll offset registers with their wrap rules.
// Offsets only ever move on the tick, so a frame is always drawn with one offset pair.
module bg_scroll_offset
    import bg_pkg::*;
#(
    parameter int V_RES = 480,
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] v_cnt,
    input  logic [1:0] scroll_mode,
    input  logic [3:0] scroll_step,
    input  logic [8:0] manual_x,
    input  logic [7:0] manual_y,
    output logic [8:0] off_x,
    output logic [7:0] off_y
);
    localparam logic [9:0] V_RES_C = 10'(V_RES);
    localparam logic [9:0] IMG_W_C = 10'(IMG_W);
    localparam logic [8:0] IMG_H_C = 9'(IMG_H);

    logic            in_frame_reg;
    logic            tick;
    logic [8:0]      off_x_reg;
    logic [8:0]      off_x_next;
    logic [7:0]      off_y_reg;
    logic [7:0]      off_y_next;
    logic [9:0]      sum_x;
    logic [8:0]      sum_y;
    bg_scroll_mode_e mode;

    assign mode  = bg_scroll_mode_e'(scroll_mode);
    assign tick  = in_frame_reg && (v_cnt >= V_RES_C);
    assign sum_x = {1'b0, off_x_reg} + {6'd0, scroll_step};
    assign sum_y = {1'b0, off_y_reg} + {5'd0, scroll_step};

    always_comb begin
        off_x_next = off_x_reg;
        off_y_next = off_y_reg;
        case (mode)
            BG_AUTO_X: off_x_next = (sum_x >= IMG_W_C) ? 9'(sum_x - IMG_W_C) : sum_x[8:0];
            BG_AUTO_Y: off_y_next = (sum_y >= IMG_H_C) ? 8'(sum_y - IMG_H_C) : sum_y[7:0];
            BG_MANUAL: begin
                // Out-of-range manual values are ignored rather than clamped.
                if ({1'b0, manual_x} < IMG_W_C) off_x_next = manual_x;
                if ({1'b0, manual_y} < IMG_H_C) off_y_next = manual_y;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_frame_reg <= 1'b0;
            off_x_reg    <= '0;
            off_y_reg    <= '0;
        end else begin
            in_frame_reg <= (v_cnt < V_RES_C);
            if (tick) begin
                off_x_reg <= off_x_next;
                off_y_reg <= off_y_next;
            end
        end
    end

    assign off_x = off_x_reg;
    assign off_y = off_y_reg;

endmodule

// File: rtl/layer_background_scroll.sv
// Scrolling background layer: counters -> wrapped source coords -> memory address
// -> external ROM read -> palette. Fixed latency of 3+MEM_LATENCY, one pixel per clock.
module layer_background_scroll
    import bg_pkg::*;
#(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int SCALE_SHIFT = 1,
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 240,
    parameter int PAL_BITS    = 4,
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 17
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [9:0]                       h_cnt,
    input  logic [9:0]                       v_cnt,
    input  logic                             valid,
    input  logic [1:0]                       scroll_mode,
    input  logic [3:0]                       scroll_step,
    input  logic [8:0]                       manual_x,
    input  logic [7:0]                       manual_y,
    layer_background_scroll_if.master        mem,
    output logic [11:0]                      pixel,
    output logic                             pixel_valid
);
    if (IMG_W != (H_RES >> SCALE_SHIFT)) begin : g_chk_img_w
        $error("IMG_W must equal H_RES >> SCALE_SHIFT");
    end
    if (MEM_LATENCY < 1 || MEM_LATENCY > 3) begin : g_chk_latency
        $error("MEM_LATENCY must be 1..3");
    end
    if ((longint'(1) << ADDR_W) < longint'(IMG_W) * longint'(IMG_H)) begin : g_chk_addr_w
        $error("ADDR_W too narrow for IMG_W*IMG_H");
    end

    localparam logic [10:0] IMG_W_S = 11'(IMG_W);
    localparam logic [10:0] IMG_H_S = 11'(IMG_H);

    logic [8:0]        off_x;
    logic [7:0]        off_y;
    logic [9:0]        h_src;
    logic [9:0]        v_src;
    logic [10:0]       sum_x;
    logic [10:0]       sum_y;
    logic [10:0]       sx_next;
    logic [10:0]       sy_next;
    logic [10:0]       sx_reg;
    logic [10:0]       sy_reg;
    logic              valid_s1_reg;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              valid_pipe_reg [0:MEM_LATENCY];
    logic [3:0]        pal_idx;
    logic [11:0]       pixel_reg;
    logic              pixel_valid_reg;

    bg_scroll_offset #(
        .V_RES (V_RES),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_offset (
        .clk         (clk),
        .rst         (rst),
        .v_cnt       (v_cnt),
        .scroll_mode (scroll_mode),
        .scroll_step (scroll_step),
        .manual_x    (manual_x),
        .manual_y    (manual_y),
        .off_x       (off_x),
        .off_y       (off_y)
    );

    // Stage 1: downscale and wrap. One subtraction suffices because both
    // operands are already below the image size inside the visible area.
    assign h_src   = h_cnt >> SCALE_SHIFT;
    assign v_src   = v_cnt >> SCALE_SHIFT;
    assign sum_x   = {1'b0, h_src} + {2'b00, off_x};
    assign sum_y   = {1'b0, v_src} + {3'b000, off_y};
    assign sx_next = (sum_x >= IMG_W_S) ? sum_x - IMG_W_S : sum_x;
    assign sy_next = (sum_y >= IMG_H_S) ? sum_y - IMG_H_S : sum_y;

    // Stage 2: linear address, formed at 32 bits then cut to the bus width.
    assign mem_addr_next = ADDR_W'(32'(sy_reg) * 32'(IMG_W) + 32'(sx_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            sx_reg       <= '0;
            sy_reg       <= '0;
            valid_s1_reg <= 1'b0;
            mem_addr_reg <= '0;
        end else begin
            sx_reg       <= sx_next;
            sy_reg       <= sy_next;
            valid_s1_reg <= valid;
            mem_addr_reg <= mem_addr_next;
        end
    end

    assign mem.mem_addr = mem_addr_reg;

    // Valid delay line: element 0 rides with mem_addr, the last one with mem_data.
    for (genvar gi = 0; gi <= MEM_LATENCY; gi++) begin : g_valid_pipe
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_pipe_reg[gi] <= 1'b0;
            end else if (gi == 0) begin
                valid_pipe_reg[gi] <= valid_s1_reg;
            end else begin
                valid_pipe_reg[gi] <= valid_pipe_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    end

    assign pal_idx = 4'(mem.mem_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_reg       <= 12'h000;
            pixel_valid_reg <= 1'b0;
        end else begin
            pixel_reg       <= valid_pipe_reg[MEM_LATENCY] ? bg_palette_lookup(pal_idx) : 12'h000;
            pixel_valid_reg <= valid_pipe_reg[MEM_LATENCY];
        end
    end

    assign pixel       = pixel_reg;
    assign pixel_valid = pixel_valid_reg;

endmodule

// File: doc/layer_background_scroll.md
# layer_background_scroll

Parametrised, pipelined background layer with frame-synchronous scrolling. It maps VGA counters (h_cnt, v_cnt) to a down-scaled source image with a per-frame X/Y offset that wraps, reads palette indices from an external synchronous memory, and outputs 12-bit RGB through a palette. It sits in the layer stack beside the sprite and overlay layers, and the compositor consumes its output. It replaces the fixed, unscrolled, latency-unaware background layer.

## Interface
Parameters:
- H_RES, 640: visible width in screen pixels.
- V_RES, 480: visible height; v_cnt reaching V_RES marks end of frame.
- SCALE_SHIFT, 1: screen-to-source downscale, as a shift amount.
- IMG_W, 320: source image width; must equal H_RES>>SCALE_SHIFT.
- IMG_H, 240: source image height.
- PAL_BITS, 4: palette index width.
- MEM_LATENCY, 1: read latency of the external memory in cycles, 1..3.
- ADDR_W, 17: memory address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- h_cnt  in  10  horizontal counter.
- v_cnt  in  10  vertical counter.
- valid  in  1  display-active flag, aligned with the counters.
- scroll_mode  in  2  00 static, 01 auto-X, 10 auto-Y, 11 manual.
- scroll_step  in  4  source pixels added per frame in auto modes.
- manual_x  in  9  X offset used in manual mode.
- manual_y  in  8  Y offset used in manual mode.
- mem_addr  out  ADDR_W  read address to the background memory.
- mem_data  in  PAL_BITS  palette index, valid MEM_LATENCY cycles after mem_addr.
- pixel  out  12  RGB 4:4:4.
- pixel_valid  out  1  the delayed valid flag.

## Operation
- Frame tick: a single-cycle internal pulse on the first cycle where v_cnt ≥ V_RES while the previous cycle had v_cnt < V_RES.
- off_x and off_y update only on a tick, so offsets never change mid-frame. Between ticks they hold.
- Offset update rules:
  - Static: offsets hold.
  - Auto-X: off_x += scroll_step; if the sum ≥ IMG_W, subtract IMG_W. off_y holds.
  - Auto-Y: the same rule on off_y with IMG_H.
  - Manual: load manual_x if it is < IMG_W, otherwise hold off_x. Load manual_y if it is < IMG_H, otherwise hold off_y.
- scroll_mode, scroll_step and manual_x/manual_y are sampled only on the tick cycle. A mode change takes effect at the next tick.
- Coordinate path:
  - sx = (h_cnt>>SCALE_SHIFT) + off_x, minus IMG_W if the result ≥ IMG_W.
  - sy = (v_cnt>>SCALE_SHIFT) + off_y, minus IMG_H if the result ≥ IMG_H.
  - mem_addr = sy*IMG_W + sx. The product is computed at full width, then truncated to ADDR_W.
- Output: pixel = BG_PALETTE[mem_data] when the delayed valid is 1, otherwise 12'h000.

## Timing
- Stage 1: register sx, sy and valid.
- Stage 2: register mem_addr.
- Stages 3..2+MEM_LATENCY: memory read. A valid shift register of matching length runs alongside it.
- Final stage: register pixel and pixel_valid.
- Latency from counters in to pixel out is 3+MEM_LATENCY cycles, which is 4 at the default setting. Throughput is one pixel per clock with no stalls.
- Offsets that change on a tick are used by stage 1 starting the following cycle.
- Reset values: off_x=0, off_y=0, mem_addr=0, pixel=12'h000, pixel_valid=0, whole valid pipeline=0, tick edge detector cleared.
- Reset mid-frame: outputs are blank for 3+MEM_LATENCY cycles after rst deasserts. Scrolling restarts from offset 0 at the next tick.
- Reset and a tick in the same cycle: reset wins, and the offsets stay 0.
- Boundaries:
  - off_x=318 with step 5 goes to 3.
  - step 0 in an auto mode holds the offsets.
  - h_cnt ≥ H_RES with valid=0 produces a blanked pixel. The memory address still computes, but its result is unused.

## Structure
- Package bg_pkg holds:
  - the scroll_mode enum (BG_STATIC, BG_AUTO_X, BG_AUTO_Y, BG_MANUAL);
  - the 16-entry BG_PALETTE constant: 222, 233, 233, ccc, 223, 233, 233, 113, 333, 233, 144, 133, 233, 323, 444, 133.
- One sub-module, bg_scroll_offset, contains the tick detector and the offset registers with their wrap logic. It outputs off_x and off_y.
- The top module holds the coordinate/address pipeline, the valid delay line and the palette stage.
- The memory stays external (a .coe-initialised block ROM) and is modelled in the bench with MEM_LATENCY.

## Test plan
- Default parameters, static mode, offsets 0: h_cnt=10, v_cnt=4, valid=1 → mem_addr=2*320+5=645 exactly 2 cycles later. With mem_data=3, pixel=12'hccc and pixel_valid=1 exactly 4 cycles after input.
- Auto-X, step=5, off_x preloaded to 318 via manual mode: at the next tick off_x=3. At h_cnt=0, v_cnt=0 the address is 3.
- Auto-Y, step=15, 20 frames: off_y follows (15*n) mod 240 and reaches 60 after 20 ticks. Offsets never change while v_cnt < V_RES.
- Manual mode with manual_x=400 (out of range) and manual_y=100: off_x holds its prior value and off_y=100. With h_cnt=639 and off_x=1, sx wraps to 0.
- valid=0 across a blanking interval → pixel=12'h000 and pixel_valid=0, with the delay matching 3+MEM_LATENCY. Repeat with MEM_LATENCY=2 and 3.
- rst asserted mid-frame coinciding with a tick → offsets 0, pixel 0 for 4 cycles after release, and no residual valid.
